addsub_pipe_ctrl: RTL and testbench
===================================

ADDSUB_PIPE_CTRL -- requirements
Module: addsub_pipe_ctrl

Interface
REQ-001 SHALL have parameter: none; all widths fixed at 32-bit datapath, 4-bit tag, 16-bit counter.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream operand request valid.
REQ-005 in_ready  output  1  block accepts request this cycle.
REQ-006 in_a, in_b  input  32 each  two's-complement operands.
REQ-007 in_op  input  1  0 = a+b, 1 = a-b.
REQ-008 in_tag  input  4  opaque ID carried to output.
REQ-009 add_a, add_b  output  32 each  operands driven to the external 32-bit carry-lookahead adder.
REQ-010 add_cin  output  1  adder carry-in.
REQ-011 add_sum  input  32, add_ovf  input  1  combinational adder result, same cycle.
REQ-012 out_valid  output  1; out_ready  input  1  result handshake.
REQ-013 out_sum  output  32, out_ovf  output  1, out_zero  output  1, out_tag  output  4  result fields.
REQ-014 ovf_clr  input  1  clears sticky flag; ovf_sticky  output  1; res_cnt  output  16  delivered-result count.

Function
REQ-015 Transfer occurs on an edge where valid and ready are both high; no other condition transfers data.
REQ-016 Stage S1: one register (valid, a, b, op, tag) loaded on input transfer.
REQ-017 add_a = S1.a; add_b = S1.op ? ~S1.b : S1.b; add_cin = S1.op; when S1 empty, add_a/add_b/add_cin SHALL be 0.
REQ-018 Output buffer: 2-entry FIFO of {sum, ovf, zero, tag}; out_* reflect the head entry; out_valid = FIFO not empty.
REQ-019 S1 advances (writes add_sum, add_ovf, zero=(add_sum==0), S1.tag into FIFO) when S1 valid and (FIFO count < 2 or an output transfer occurs the same cycle).
REQ-020 in_ready = !S1.valid or S1 advances this cycle; combinational path out_ready -> in_ready is permitted.
REQ-021 Simultaneous S1 advance and new input transfer SHALL reload S1 with no bubble; sustained throughput 1 result/cycle when out_ready held high.
REQ-022 Latency: operand accepted at edge N appears with out_valid=1 after edge N+1 (2 edges accept-to-visible) when FIFO not blocked.
REQ-023 Results SHALL emerge in acceptance order; no drop, no duplication.
REQ-024 Full FIFO, out_ready=0, S1 valid: in_ready=0, S1 and FIFO hold, out_* stable.
REQ-025 FIFO simultaneous push and pop: count unchanged, pointers wrap mod 2.
REQ-026 ovf_sticky sets on the edge an entry with ovf=1 is pushed; ovf_clr clears it; set and clear same edge -> set wins.
REQ-027 res_cnt increments on each output transfer, wraps 0xFFFF -> 0x0000.
REQ-028 Adder outputs not sampled when S1 empty.

Reset
REQ-029 On rst_n low (any time, asynchronously): S1 invalid, FIFO empty, pointers 0, ovf_sticky=0, res_cnt=0.
REQ-030 During and after reset: out_valid=0, out_sum=0, out_ovf=0, out_zero=0, out_tag=0, add_a=add_b=0, add_cin=0, in_ready=1 from first edge after release.
REQ-031 Reset mid-operation SHALL discard all in-flight operands and results; none emerge after release.

Verification
REQ-032 Add: a=0x7FFFFFFF, b=0x00000001, op=0, tag=3 -> out_sum=0x80000000, out_ovf=1, out_zero=0, tag=3, ovf_sticky=1, visible 2 edges after accept.
REQ-033 Subtract: a=0x00000005, b=0x00000005, op=1 -> add_b=0xFFFFFFFA, add_cin=1, out_sum=0, out_zero=1, out_ovf=0; a=0x80000000, b=1, op=1 -> 0x7FFFFFFF, ovf=1.
REQ-034 Backpressure: out_ready=0, send 4 requests -> 3 accepted (2 FIFO + S1), in_ready=0; then out_ready=1 -> 3 results in tag order, 4th accepted on first freed cycle.
REQ-035 Streaming: in_valid=out_ready=1 for 100 cycles, random operands -> 100 results back-to-back, each matches a±b mod 2^32, res_cnt=100.
REQ-036 Reset asserted with S1 and FIFO full -> outputs zero immediately, after release no stale result; res_cnt starting 0xFFFF increments to 0x0000; ovf_clr with simultaneous overflow push -> ovf_sticky stays 1.

Source files
------------

// File: rtl/addsub_pipe_ctrl.sv
// addsub_pipe_ctrl
//   Add/subtract pipeline controller for an external 32-bit carry-lookahead
//   adder. Requests are captured in a single operand stage (S1). S1 drives the
//   adder. The combinational adder result is written into a 2-entry output
//   FIFO. A sticky overflow flag and a delivered-result counter are kept.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          request handshake
//   in_a, in_b, in_op, in_tag  operands, op (0 = a+b, 1 = a-b), opaque tag
//   add_a, add_b, add_cin      operands to the external adder
//   add_sum, add_ovf           combinational adder result
//   out_valid/out_ready        result handshake
//   out_sum, out_ovf,
//   out_zero, out_tag          head-of-FIFO result fields
//   ovf_clr, ovf_sticky        sticky overflow clear / flag
//   res_cnt                    delivered-result count, wraps
module addsub_pipe_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_op,
  input  logic [3:0]  in_tag,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_cin,
  input  logic [31:0] add_sum,
  input  logic        add_ovf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic        out_ovf,
  output logic        out_zero,
  output logic [3:0]  out_tag,
  input  logic        ovf_clr,
  output logic        ovf_sticky,
  output logic [15:0] res_cnt
);

  logic        s1_valid;
  logic [31:0] s1_a;
  logic [31:0] s1_b;
  logic        s1_op;
  logic [3:0]  s1_tag;

  logic [31:0] fifo_sum  [2];
  logic        fifo_ovf  [2];
  logic        fifo_zero [2];
  logic [3:0]  fifo_tag  [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;

  logic out_xfer;
  logic s1_adv;
  logic in_xfer;

  always_comb begin
    out_valid = (count != 2'd0);
    out_xfer  = out_valid & out_ready;
    // S1 may drain into a full FIFO only when the head leaves on the same edge.
    s1_adv    = s1_valid & ((count != 2'd2) | out_xfer);
    in_ready  = ~s1_valid | s1_adv;
    in_xfer   = in_valid & in_ready;

    add_a   = 32'd0;
    add_b   = 32'd0;
    add_cin = 1'b0;
    if (s1_valid) begin
      add_a   = s1_a;
      add_b   = s1_op ? ~s1_b : s1_b;
      add_cin = s1_op;
    end

    // Result fields read zero while the FIFO is empty so stale entries never
    // show up after a drain or a reset.
    out_sum  = 32'd0;
    out_ovf  = 1'b0;
    out_zero = 1'b0;
    out_tag  = 4'd0;
    if (out_valid) begin
      out_sum  = fifo_sum[rd_ptr];
      out_ovf  = fifo_ovf[rd_ptr];
      out_zero = fifo_zero[rd_ptr];
      out_tag  = fifo_tag[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= 32'd0;
      s1_b     <= 32'd0;
      s1_op    <= 1'b0;
      s1_tag   <= 4'd0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_op    <= in_op;
      s1_tag   <= in_tag;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_sum[i]  <= 32'd0;
        fifo_ovf[i]  <= 1'b0;
        fifo_zero[i] <= 1'b0;
        fifo_tag[i]  <= 4'd0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (s1_adv) begin
        fifo_sum[wr_ptr]  <= add_sum;
        fifo_ovf[wr_ptr]  <= add_ovf;
        fifo_zero[wr_ptr] <= (add_sum == 32'd0);
        fifo_tag[wr_ptr]  <= s1_tag;
        wr_ptr            <= ~wr_ptr;
      end
      if (out_xfer) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({s1_adv, out_xfer})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      res_cnt    <= 16'd0;
    end else begin
      // A push carrying an overflow takes priority over a clear on the same edge.
      if (s1_adv && add_ovf) begin
        ovf_sticky <= 1'b1;
      end else if (ovf_clr) begin
        ovf_sticky <= 1'b0;
      end
      if (out_xfer) begin
        res_cnt <= res_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe_ctrl.sv
module tb_addsub_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_op;
  logic [3:0]  in_tag;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_ovf;
  logic        out_zero;
  logic [3:0]  out_tag;
  logic        ovf_clr;
  logic        ovf_sticky;
  logic [15:0] res_cnt;

  always #5 clk = ~clk;

  addsub_pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_ovf(add_ovf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .out_zero(out_zero), .out_tag(out_tag),
    .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky), .res_cnt(res_cnt)
  );

  // External carry-lookahead adder stand-in: signed overflow when both
  // addends share a sign that the sum does not.
  assign add_sum = add_a + add_b + {31'd0, add_cin};
  assign add_ovf = (add_a[31] == add_b[31]) && (add_sum[31] != add_a[31]);

  typedef struct packed {
    logic [31:0] sum;
    logic        ovf;
    logic        zero;
    logic [3:0]  tag;
  } res_t;

  res_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  int   n_push   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic written from the operation itself, not the adder form.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic op, input logic [3:0] tag);
    res_t r;
    if (op) begin
      r.sum = a - b;
      r.ovf = (a[31] != b[31]) && (r.sum[31] != a[31]);
    end else begin
      r.sum = a + b;
      r.ovf = (a[31] == b[31]) && (r.sum[31] != a[31]);
    end
    r.zero = (r.sum == 32'd0);
    r.tag  = tag;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_out++;
        chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          res_t e;
          e = sb.pop_front();
          chk("sb_sum", out_sum, e.sum);
          chk("sb_ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
          chk("sb_zero", {31'd0, out_zero}, {31'd0, e.zero});
          chk("sb_tag", {28'd0, out_tag}, {28'd0, e.tag});
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_a, in_b, in_op, in_tag));
        n_push++;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic op, input logic [3:0] tag);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_tag   = tag;
  endtask

  task automatic drain();
    int k = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb.size() != 0 && k < 100) begin
      step();
      k++;
    end
    chk("drain_done", sb.size(), 32'd0);
  endtask

  task automatic stream(input int n, output int stalls);
    stalls = 0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      drive($urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      #1;
      if (!in_ready) stalls++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int stalls;
    int out0;
    int push0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 32'd0;
    in_b      = 32'd0;
    in_op     = 1'b0;
    in_tag    = 4'd0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;

    // Reset values
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sum", out_sum, 32'd0);
    chk("rst_add_a", add_a, 32'd0);
    chk("rst_add_b", add_b, 32'd0);
    chk("rst_add_cin", {31'd0, add_cin}, 32'd0);
    chk("rst_sticky", {31'd0, ovf_sticky}, 32'd0);
    chk("rst_res_cnt", {16'd0, res_cnt}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Signed add overflow, two-edge latency
    drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4'd3);
    step();
    in_valid = 1'b0;
    #1;
    chk("add_a_s1", add_a, 32'h7FFF_FFFF);
    chk("add_b_s1", add_b, 32'h0000_0001);
    chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
    step();
    chk("lat_visible", {31'd0, out_valid}, 32'd1);
    chk("ovf_sum", out_sum, 32'h8000_0000);
    chk("ovf_flag", {31'd0, out_ovf}, 32'd1);
    chk("ovf_zero", {31'd0, out_zero}, 32'd0);
    chk("ovf_tag", {28'd0, out_tag}, 32'd3);
    chk("ovf_sticky_set", {31'd0, ovf_sticky}, 32'd1);
    chk("idle_add_a", add_a, 32'd0);
    drain();
    chk("res_cnt_1", {16'd0, res_cnt}, 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("sticky_clr", {31'd0, ovf_sticky}, 32'd0);

    // Subtract to zero
    out_ready = 1'b0;
    drive(32'd5, 32'd5, 1'b1, 4'd4);
    step();
    in_valid = 1'b0;
    #1;
    chk("sub_add_b", add_b, 32'hFFFF_FFFA);
    chk("sub_add_cin", {31'd0, add_cin}, 32'd1);
    step();
    chk("sub_sum", out_sum, 32'd0);
    chk("sub_zero", {31'd0, out_zero}, 32'd1);
    chk("sub_ovf", {31'd0, out_ovf}, 32'd0);
    drain();

    // Subtract with overflow
    out_ready = 1'b0;
    drive(32'h8000_0000, 32'd1, 1'b1, 4'd5);
    step();
    in_valid = 1'b0;
    step();
    chk("subovf_sum", out_sum, 32'h7FFF_FFFF);
    chk("subovf_ovf", {31'd0, out_ovf}, 32'd1);
    drain();

    // Backpressure: three fit (2 FIFO + S1), the fourth waits
    out_ready = 1'b0;
    push0 = n_push;
    for (int i = 0; i < 3; i++) begin
      drive(32'd100 + 32'(i), 32'd7, 1'b0, 4'(8 + i));
      #1;
      chk("bp_ready_free", {31'd0, in_ready}, 32'd1);
      step();
    end
    drive(32'd200, 32'd7, 1'b1, 4'd11);
    #1;
    chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
    step();
    chk("bp_ready_hold", {31'd0, in_ready}, 32'd0);
    chk("bp_accepted3", n_push - push0, 32'd3);
    chk("bp_head_tag", {28'd0, out_tag}, 32'd8);
    chk("bp_head_sum", out_sum, 32'd107);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_freed", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp_accepted4", n_push - push0, 32'd4);
    drain();

    // Streaming from reset: 100 back-to-back results
    rst_n = 1'b0;
    sb.delete();
    #2;
    rst_n = 1'b1;
    step();
    out0 = n_out;
    stream(100, stalls);
    drain();
    chk("stream_stalls", stalls, 32'd0);
    chk("stream_results", n_out - out0, 32'd100);
    chk("stream_res_cnt", {16'd0, res_cnt}, 32'd100);

    // Counter wrap 0xFFFF -> 0x0000
    stream(65435, stalls);
    drain();
    chk("wrap_ffff", {16'd0, res_cnt}, 32'h0000_FFFF);
    stream(1, stalls);
    drain();
    chk("wrap_zero", {16'd0, res_cnt}, 32'd0);

    // Overflow push and clear on the same edge: set wins
    out_ready = 1'b1;
    drive(32'h7FFF_FFFF, 32'd1, 1'b0, 4'd1);
    step();
    drive(32'h4000_0000, 32'h4000_0000, 1'b0, 4'd2);
    step();
    chk("sticky_first", {31'd0, ovf_sticky}, 32'd1);
    in_valid = 1'b0;
    ovf_clr  = 1'b1;
    step();
    chk("sticky_set_wins", {31'd0, ovf_sticky}, 32'd1);
    step();
    ovf_clr = 1'b0;
    chk("sticky_clr2", {31'd0, ovf_sticky}, 32'd0);
    drain();

    // Reset with S1 and FIFO full discards everything
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'd9, 32'(i), 1'b0, 4'(12 + i));
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_sum", out_sum, 32'd0);
    chk("mid_rst_out_tag", {28'd0, out_tag}, 32'd0);
    chk("mid_rst_add_a", add_a, 32'd0);
    chk("mid_rst_res_cnt", {16'd0, res_cnt}, 32'd0);
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    out0 = n_out;
    for (int i = 0; i < 5; i++) step();
    chk("no_stale_out", n_out - out0, 32'd0);
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
